// File: rtl/bitplane_fetch_window_if.sv
// Beam position, register bus and bitplane DMA sequencer outputs of the bitplane fetch window.
interface bitplane_fetch_window_if;
    logic [8:0]  hpos;
    logic [10:0] vpos;
    logic        vbl;
    logic        eof;
    logic [15:0] datain;
    logic [7:0]  regaddressin;
    logic        vdiw;
    logic        ddf_active;
    logic        dma_req;
    logic [2:0]  plane;
    logic        plane0_fetch;
    logic        mod_add;

    modport master (
        output hpos, vpos, vbl, eof, datain, regaddressin,
        input  vdiw, ddf_active, dma_req, plane, plane0_fetch, mod_add
    );

    modport slave (
        input  hpos, vpos, vbl, eof, datain, regaddressin,
        output vdiw, ddf_active, dma_req, plane, plane0_fetch, mod_add
    );
endinterface

// File: rtl/bitplane_fetch_window.sv
// Vertical display window, horizontal data-fetch window and per-CCK bitplane DMA slot sequencer
// driven by the beam counter; emits the end-of-line modulo strobe.
module bitplane_fetch_window #(
    parameter logic [7:0] DDF_LIMIT = 8'hD8,
    parameter int         BLOCK_LEN = 8
) (
    input logic                    clk,
    input logic                    reset,
    bitplane_fetch_window_if.slave bus
);
    // Register addresses as seen on regaddressin (byte address bits [8:1])
    localparam logic [7:0] ADDR_DIWSTRT = 8'h47;
    localparam logic [7:0] ADDR_DIWSTOP = 8'h48;
    localparam logic [7:0] ADDR_DDFSTRT = 8'h49;
    localparam logic [7:0] ADDR_DDFSTOP = 8'h4A;
    localparam logic [7:0] ADDR_BPLCON0 = 8'h80;

    // 1-based plane per slot, k=7 in the top field; 0 marks a free slot
    localparam logic [23:0] LORES_MAP = {3'd1, 3'd5, 3'd3, 3'd0, 3'd2, 3'd6, 3'd4, 3'd0};
    localparam logic [23:0] HIRES_MAP = {3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd3, 3'd2, 3'd4};
    localparam logic [2:0]  K_LAST    = 3'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  k_reg;
    logic [8:0]  block_start_reg;
    logic [7:0]  vstart_reg, vstop_reg, ddfstrt_reg, ddfstop_reg;
    logic        vstop_msb_reg;
    logic        hires_reg;
    logic [2:0]  bpu_reg;
    logic        vdiw_reg, ddf_active_reg, dma_req_reg, plane0_fetch_reg, mod_add_reg;
    logic [2:0]  plane_reg;

    logic [2:0]  bpu_eff;
    logic [8:0]  vstart, vstop;
    logic [7:0]  fstart, fstop, cck;
    logic        cck_end, wrap, stop_hit, limit_hit, start_ok;
    logic [8:0]  next_start;
    logic [2:0]  slot_num [8];
    logic [7:0]  slot_req;
    logic        unused_vpos;

    assign unused_vpos = ^bus.vpos[10:9];

    assign bpu_eff = (bpu_reg > 3'd6) ? 3'd4 : bpu_reg;
    assign vstart  = {1'b0, vstart_reg};
    assign vstop   = {~vstop_msb_reg, vstop_reg};
    assign fstart  = hires_reg ? {ddfstrt_reg[7:2], 2'b00} : {ddfstrt_reg[7:3], 3'b000};
    assign fstop   = hires_reg ? {ddfstop_reg[7:2], 2'b00} : {ddfstop_reg[7:3], 3'b000};
    assign cck     = bus.hpos[8:1];
    assign cck_end = bus.hpos[0];
    assign wrap    = cck_end && (k_reg == K_LAST) && (state_reg != IDLE);

    assign next_start = block_start_reg + 9'(BLOCK_LEN);
    // A stop set before the start is never reached this line, so only the hardware limit ends it
    assign stop_hit   = (fstop >= fstart) && (block_start_reg >= {1'b0, fstop});
    assign limit_hit  = next_start > {1'b0, DDF_LIMIT};
    assign start_ok   = !cck_end && (cck == fstart) && vdiw_reg &&
                        (bpu_eff != 3'd0) && (fstart <= DDF_LIMIT);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            assign slot_num[gi] = hires_reg ? HIRES_MAP[gi*3 +: 3] : LORES_MAP[gi*3 +: 3];
            assign slot_req[gi] = (slot_num[gi] != 3'd0) && (slot_num[gi] <= bpu_eff);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            vstart_reg    <= '0;
            vstop_reg     <= '0;
            vstop_msb_reg <= 1'b0;
            ddfstrt_reg   <= '0;
            ddfstop_reg   <= '0;
            hires_reg     <= 1'b0;
            bpu_reg       <= '0;
        end else begin
            case (bus.regaddressin)
                ADDR_DIWSTRT: vstart_reg <= bus.datain[15:8];
                ADDR_DIWSTOP: begin
                    vstop_reg     <= bus.datain[15:8];
                    vstop_msb_reg <= bus.datain[15];
                end
                ADDR_DDFSTRT: ddfstrt_reg <= bus.datain[7:0];
                ADDR_DDFSTOP: ddfstop_reg <= bus.datain[7:0];
                ADDR_BPLCON0: begin
                    hires_reg <= bus.datain[15];
                    bpu_reg   <= bus.datain[14:12];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = FETCH;
            FETCH:   if (stop_hit || limit_hit) state_next = LAST;
            LAST:    if (wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            k_reg            <= '0;
            block_start_reg  <= '0;
            vdiw_reg         <= 1'b0;
            ddf_active_reg   <= 1'b0;
            dma_req_reg      <= 1'b0;
            plane_reg        <= '0;
            plane0_fetch_reg <= 1'b0;
            mod_add_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ddf_active_reg <= (state_next != IDLE);
            mod_add_reg    <= (state_reg == LAST) && wrap;

            if (state_reg == IDLE) begin
                if (state_next == FETCH) begin
                    k_reg           <= '0;
                    block_start_reg <= {1'b0, fstart};
                end
            end else if (cck_end) begin
                k_reg <= wrap ? 3'd0 : k_reg + 3'd1;
                if (wrap) block_start_reg <= next_start;
            end

            // Slot decision lands at the CCK boundary and is held for the whole following CCK
            if (cck_end) begin
                dma_req_reg      <= (state_reg != IDLE) && slot_req[k_reg];
                plane_reg        <= ((state_reg != IDLE) && slot_req[k_reg]) ?
                                    3'(slot_num[k_reg] - 3'd1) : 3'd0;
                plane0_fetch_reg <= (state_reg != IDLE) && slot_req[k_reg] &&
                                    (slot_num[k_reg] == 3'd1);
            end

            if (bus.vbl || bus.eof) begin
                vdiw_reg <= 1'b0;
            end else if (bus.hpos == 9'd4) begin
                if (bus.vpos[8:0] == vstop)       vdiw_reg <= 1'b0;
                else if (bus.vpos[8:0] == vstart) vdiw_reg <= 1'b1;
            end
        end
    end

    assign bus.vdiw         = vdiw_reg;
    assign bus.ddf_active   = ddf_active_reg;
    assign bus.dma_req      = dma_req_reg;
    assign bus.plane        = plane_reg;
    assign bus.plane0_fetch = plane0_fetch_reg;
    assign bus.mod_add      = mod_add_reg;
endmodule

// File: tb/tb_bitplane_fetch_window.sv
// Scoreboard bench for bitplane_fetch_window: expected DMA slots and mod_add strobes are queued per line.
module tb_bitplane_fetch_window;
    localparam int LINE_CLKS = 454;
    localparam int LORES_MAP [8] = '{0, 4, 6, 2, 0, 3, 5, 1};
    localparam int HIRES_MAP [8] = '{4, 2, 3, 1, 4, 2, 3, 1};

    typedef struct {
        int cck;
        int plane;
    } req_t;

    logic clk;
    logic reset;
    bitplane_fetch_window_if bus();

    bitplane_fetch_window #(.DDF_LIMIT(8'hD8), .BLOCK_LEN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_t rq[$];
    int   mq[$];
    int   checks = 0;
    int   failures = 0;
    int   line_reqs;
    logic seen_active;
    logic line_vdiw;
    logic exp_req = 1'b0;
    int   exp_plane = 0;

    task automatic write_reg(input logic [8:0] addr, input logic [15:0] data);
        bus.regaddressin = addr[8:1];
        bus.datain       = data;
        @(posedge clk); #1;
        bus.regaddressin = 8'hFF;
    endtask

    task automatic push_fetch(input bit hr, input int start, input int nblk, input int bpu);
        int p;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 8; k++) begin
                p = hr ? HIRES_MAP[k] : LORES_MAP[k];
                if (p != 0 && p <= bpu) rq.push_back('{start + 8*b + k + 1, p - 1});
            end
        end
        mq.push_back(2 * (start + 8*nblk));
    endtask

    // Runs beam positions h_first..h_end-1 of one line and retires scoreboard entries as the DUT produces them
    task automatic run_line(input int v, input bit vb, input bit ef, input int h_first, input int h_end);
        logic exp_mod;
        line_reqs   = 0;
        seen_active = 1'b0;
        for (int h = h_first; h < h_end; h++) begin
            bus.hpos = 9'(h);
            if (h == 4) begin
                bus.vpos = 11'(v);
                bus.vbl  = vb;
                bus.eof  = ef;
            end
            if (h == 5) bus.eof = 1'b0;
            if (h % 2 == 0) begin
                exp_req   = (rq.size() > 0) && (rq[0].cck == h / 2);
                exp_plane = exp_req ? rq[0].plane : 0;
                if (exp_req) void'(rq.pop_front());
            end
            checks++;
            if (bus.dma_req !== exp_req) begin
                failures++;
                $display("FAIL dma_req vpos=%0h hpos=%0h got=%b exp=%b", v, h, bus.dma_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (bus.plane !== 3'(exp_plane)) begin
                    failures++;
                    $display("FAIL plane vpos=%0h hpos=%0h got=%0d exp=%0d", v, h, bus.plane, exp_plane);
                end
            end
            checks++;
            if (bus.plane0_fetch !== (exp_req && exp_plane == 0)) begin
                failures++;
                $display("FAIL plane0_fetch vpos=%0h hpos=%0h got=%b exp=%b", v, h,
                         bus.plane0_fetch, exp_req && exp_plane == 0);
            end
            exp_mod = (mq.size() > 0) && (mq[0] == h);
            if (exp_mod) void'(mq.pop_front());
            checks++;
            if (bus.mod_add !== exp_mod) begin
                failures++;
                $display("FAIL mod_add vpos=%0h hpos=%0h got=%b exp=%b", v, h, bus.mod_add, exp_mod);
            end
            if (bus.dma_req === 1'b1 && h % 2 == 0) line_reqs++;
            if (bus.ddf_active === 1'b1) seen_active = 1'b1;
            if (h == 10) line_vdiw = bus.vdiw;
            @(posedge clk); #1;
        end
    endtask

    task automatic end_of_line(input string name, input int want_reqs);
        checks++;
        if (line_reqs != want_reqs) begin
            failures++;
            $display("FAIL %s req_count got=%0d exp=%0d", name, line_reqs, want_reqs);
        end
        checks++;
        if (rq.size() != 0 || mq.size() != 0) begin
            failures++;
            $display("FAIL %s leftover got=%0d/%0d exp=0/0", name, rq.size(), mq.size());
        end
        rq.delete();
        mq.delete();
        $display("line %s: requests=%0d expected=%0d", name, line_reqs, want_reqs);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus.vdiw, bus.ddf_active, bus.dma_req, bus.plane, bus.plane0_fetch, bus.mod_add} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {bus.vdiw, bus.ddf_active, bus.dma_req, bus.plane, bus.plane0_fetch, bus.mod_add});
        end
        $display("reset: outputs=%b", {bus.vdiw, bus.ddf_active, bus.dma_req, bus.plane, bus.plane0_fetch, bus.mod_add});
    endtask

    task automatic test_vertical_window();
        int   vp [9] = '{'h2B, 'h2C, 'h12B, 'h12C, 'h2C, 'h2C, 'h2C, 'h2D, 'h2E};
        bit   vb [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        bit   ef [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic ew [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        write_reg(9'h08E, 16'h2C81);
        write_reg(9'h090, 16'h2CC1);
        for (int i = 0; i < 9; i++) begin
            run_line(vp[i], vb[i], ef[i], 0, LINE_CLKS);
            checks++;
            if (line_vdiw !== ew[i]) begin
                failures++;
                $display("FAIL vdiw vpos=%0h vbl=%0d eof=%0d got=%b exp=%b", vp[i], vb[i], ef[i], line_vdiw, ew[i]);
            end
            $display("vwin: vpos=%0h vbl=%0d eof=%0d vdiw=%b", vp[i], vb[i], ef[i], line_vdiw);
        end
        bus.vbl = 1'b0;
    endtask

    task automatic test_lores();
        write_reg(9'h100, 16'h4000);
        write_reg(9'h092, 16'h0038);
        write_reg(9'h094, 16'h00D0);
        run_line('h40, 0, 0, 0, LINE_CLKS);
        end_of_line("lores_closed", 0);
        push_fetch(0, 'h38, 20, 4);
        run_line('h2C, 0, 0, 0, LINE_CLKS);
        end_of_line("lores_open", 80);
    endtask

    task automatic test_back_to_back();
        push_fetch(0, 'h38, 20, 4);
        run_line('h2D, 0, 0, 0, LINE_CLKS);
        end_of_line("lores_next_line", 80);
    endtask

    task automatic test_hires();
        write_reg(9'h100, 16'hC000);
        write_reg(9'h092, 16'h003C);
        write_reg(9'h094, 16'h00D4);
        push_fetch(1, 'h3C, 20, 4);
        run_line('h2E, 0, 0, 0, LINE_CLKS);
        end_of_line("hires", 160);
    endtask

    task automatic test_stop_before_start();
        write_reg(9'h100, 16'h4000);
        write_reg(9'h092, 16'h0038);
        write_reg(9'h094, 16'h0020);
        push_fetch(0, 'h38, 21, 4);
        run_line('h2F, 0, 0, 0, LINE_CLKS);
        end_of_line("stop_before_start", 84);
    endtask

    task automatic test_bpu_counts();
        write_reg(9'h094, 16'h00D0);
        write_reg(9'h100, 16'h6000);
        push_fetch(0, 'h38, 20, 6);
        run_line('h30, 0, 0, 0, LINE_CLKS);
        end_of_line("bpu6", 120);
        write_reg(9'h100, 16'h7000);
        push_fetch(0, 'h38, 20, 4);
        run_line('h31, 0, 0, 0, LINE_CLKS);
        end_of_line("bpu7", 80);
        write_reg(9'h100, 16'h0000);
        run_line('h32, 0, 0, 0, LINE_CLKS);
        end_of_line("bpu0", 0);
        checks++;
        if (seen_active !== 1'b0 || line_vdiw !== 1'b1) begin
            failures++;
            $display("FAIL bpu0_idle ddf_active_seen=%b vdiw=%b exp=0/1", seen_active, line_vdiw);
        end
    endtask

    task automatic test_reset_mid_line();
        write_reg(9'h100, 16'h4000);
        rq.push_back('{'h3A, 3});
        rq.push_back('{'h3C, 1});
        run_line('h2C, 0, 0, 0, 2 * 'h3D);
        bus.hpos = 9'(2 * 'h3D);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_req = 1'b0;
        checks++;
        if ({bus.ddf_active, bus.dma_req, bus.mod_add} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid ddf_active/dma_req/mod_add got=%b exp=000",
                     {bus.ddf_active, bus.dma_req, bus.mod_add});
        end
        $display("reset_mid: ddf_active=%b dma_req=%b mod_add=%b", bus.ddf_active, bus.dma_req, bus.mod_add);
        run_line('h2C, 0, 0, 2 * 'h3D + 1, LINE_CLKS);
        end_of_line("after_reset_rest", 0);
        write_reg(9'h08E, 16'h2C81);
        write_reg(9'h090, 16'h2CC1);
        write_reg(9'h100, 16'h4000);
        write_reg(9'h092, 16'h0038);
        write_reg(9'h094, 16'h00D0);
        push_fetch(0, 'h38, 20, 4);
        run_line('h2C, 0, 0, 0, LINE_CLKS);
        end_of_line("resume", 80);
    endtask

    initial begin
        reset            = 1'b1;
        bus.hpos         = '0;
        bus.vpos         = '0;
        bus.vbl          = 1'b0;
        bus.eof          = 1'b0;
        bus.datain       = '0;
        bus.regaddressin = 8'hFF;
        test_reset();
        test_vertical_window();
        test_lores();
        test_back_to_back();
        test_hires();
        test_stop_before_start();
        test_bpu_counts();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
